// File: rtl/ooo_pkg.sv
// Shared out-of-order core definitions for the reservation station slot logic.
package ooo_pkg;

  localparam int NUM_RS_SLOTS = 4;
  localparam int RS_IDX_W     = 2;

  typedef logic [RS_IDX_W-1:0]     rs_idx_t;
  typedef logic [NUM_RS_SLOTS-1:0] rs_mask_t;

  // Number of clear bits in an occupancy mask; result spans 0..NUM_RS_SLOTS.
  function automatic logic [RS_IDX_W:0] count_clear(input rs_mask_t mask);
    logic [RS_IDX_W:0] total;
    total = '0;
    for (int i = 0; i < NUM_RS_SLOTS; i++) begin
      if (!mask[i]) total = total + 1'b1;
    end
    return total;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Rotating-priority picker over four slots: the first available slot at or after
// the start index (wrapping) wins. With nothing available, idx stays at start
// so the downstream decoder address remains stable.
module rr_pick4
  import ooo_pkg::*;
(
  input  logic [3:0] avail,
  input  logic [1:0] start,
  output logic       found,
  output logic [1:0] idx
);

  // Walk start, start+1, ... modulo 4 and latch the first available candidate.
  always_comb begin
    logic [1:0] cand;
    found = 1'b0;
    idx   = start;
    cand  = start;
    for (int i = 0; i < 4; i++) begin
      cand = start + 2'(i);
      if (!found && avail[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/rs_slot_allocator.sv
// Reservation station slot allocator: round-robin selection of a free entry,
// occupancy tracking across dispatch/issue-release/flush, and a pulse when the
// issue side releases a slot that was not occupied.
module rs_slot_allocator
  import ooo_pkg::*;
#(
  parameter int NUM_SLOTS = NUM_RS_SLOTS,
  parameter int IDX_W     = $clog2(NUM_SLOTS)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 alloc_req,
  output logic                 alloc_ready,
  output logic [IDX_W-1:0]     alloc_addr,
  output logic                 alloc_en,
  input  logic [NUM_SLOTS-1:0] free_vec,
  input  logic                 flush,
  output logic [NUM_SLOTS-1:0] busy,
  output logic [IDX_W:0]       free_count,
  output logic                 err_free
);

  // The write-select decoder downstream is strictly 2-to-4.
  if (NUM_SLOTS != 4) begin : g_bad_slots
    $error("rs_slot_allocator: NUM_SLOTS must be 4");
  end

  rs_idx_t  rr_ptr;
  rs_mask_t busy_next;
  rs_idx_t  rr_ptr_next;
  logic     err_next;
  logic     pick_found;
  rs_idx_t  pick_idx;
  rs_mask_t alloc_mask;

  // Selection works from registered occupancy, so a slot freed this cycle is
  // only offered from the next cycle onward.
  rr_pick4 u_pick (
    .avail (~busy),
    .start (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign alloc_ready = pick_found;
  assign alloc_addr  = pick_idx;
  assign alloc_en    = alloc_req & pick_found & ~flush;

  // Next occupancy, pointer and error flag; the alloc set is applied after the
  // release mask so it wins on a shared slot, and flush overrides everything.
  always_comb begin
    alloc_mask  = '0;
    busy_next   = busy;
    rr_ptr_next = rr_ptr;
    err_next    = 1'b0;
    if (alloc_en) alloc_mask = rs_mask_t'(1) << alloc_addr;
    if (flush) begin
      busy_next   = '0;
      rr_ptr_next = '0;
    end else begin
      busy_next = (busy & ~free_vec) | alloc_mask;
      err_next  = |(free_vec & ~busy);
      if (alloc_en) rr_ptr_next = alloc_addr + 1'b1;
    end
  end

  // State registers; reset returns to an empty station with the pointer at slot 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy       <= '0;
      rr_ptr     <= '0;
      free_count <= (IDX_W+1)'(NUM_SLOTS);
      err_free   <= 1'b0;
    end else begin
      busy       <= busy_next;
      rr_ptr     <= rr_ptr_next;
      free_count <= count_clear(busy_next);
      err_free   <= err_next;
    end
  end

endmodule
